// File: rtl/edge_pkg.sv
// Shared definitions for the debounced edge detector.
//   EDGE_*      : per-channel edge_mode encodings
//   clog2_min1  : counter width helper, never returns less than 1
package edge_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  function automatic int clog2_min1(input int value);
    int r;
    r = $clog2(value);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchroniser, counter-based debouncer and edge qualifier.
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   sig_i        raw asynchronous input
//   mode_i       edge_mode pair for this channel (bit0 rising, bit1 falling)
//   level_o      registered debounced level
//   pulse_o      registered one-cycle event pulse
//   pulse_next_o value pulse_o takes on the next edge (feeds the top's any_edge register)
module debounce_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig_i,
  input  logic [1:0] mode_i,
  output logic       level_o,
  output logic       pulse_o,
  output logic       pulse_next_o
);

  localparam int CNT_W = clog2_min1(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sig_i};
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    if (s == level_q) begin
      // any return to the current level restarts the stability window
      cnt_d = '0;
    end else if (cnt_q == CNT_TC) begin
      level_d = s;
      cnt_d   = '0;
      // mode is only looked at on the edge that actually moves the level
      pulse_d = s ? ((mode_i & EDGE_RISE) != 2'b00) : ((mode_i & EDGE_FALL) != 2'b00);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o      = level_q;
  assign pulse_o      = pulse_q;
  assign pulse_next_o = pulse_d;

endmodule

// File: rtl/debounced_edge_detector.sv
// Multi-channel input conditioner: WIDTH independent debounce channels plus a
// registered any_edge flag that is high in the same cycle as any pulse.
// Ports:
//   clk               system clock
//   rst_n             synchronous active-low reset
//   signal_in         raw asynchronous inputs
//   edge_mode         per channel [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
//   level_out         debounced levels
//   edge_detect_pulse one-cycle pulses on qualifying debounced transitions
//   any_edge          OR of edge_detect_pulse, registered alongside it
module debounced_edge_detector
  import edge_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   signal_in,
  input  logic [2*WIDTH-1:0] edge_mode,
  output logic [WIDTH-1:0]   level_out,
  output logic [WIDTH-1:0]   edge_detect_pulse,
  output logic               any_edge
);

  logic [WIDTH-1:0] pulse_next;
  logic             any_edge_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .sig_i        (signal_in[i]),
      .mode_i       (edge_mode[2*i+1:2*i]),
      .level_o      (level_out[i]),
      .pulse_o      (edge_detect_pulse[i]),
      .pulse_next_o (pulse_next[i])
    );
  end

  // built from next-state pulses so it lines up with edge_detect_pulse
  always_ff @(posedge clk) begin
    if (!rst_n) any_edge_q <= 1'b0;
    else        any_edge_q <= |pulse_next;
  end

  assign any_edge = any_edge_q;

endmodule
